// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: KSA state encoding and key byte selection.
// Also used by the PRGA/decrypt FSM.
package rc4_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StInit,
        StRdSi,
        StWaitSi,
        StCalcJ,
        StWaitSj,
        StWrSi,
        StWrSj,
        StDone
    } ksa_state_t;

    localparam int unsigned MaxKeyBytes = 32;

    // Byte 0 is the most significant byte of the key_bytes-wide key.
    function automatic logic [7:0] key_byte(input logic [MaxKeyBytes*8-1:0] key,
                                            input int unsigned             key_bytes,
                                            input int unsigned             k);
        logic [MaxKeyBytes*8-1:0] sh;
        sh = key >> ((key_bytes - 1 - k) * 8);
        return sh[7:0];
    endfunction

endpackage

// File: rtl/rc4_ksa_engine_if.sv
// Control handshake and S RAM port of the RC4 key-scheduling engine.
interface rc4_ksa_engine_if #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned KEY_BYTES = 3
);
    logic                   start;
    logic                   init_en;
    logic [KEY_BYTES*8-1:0] secret_key;
    logic                   busy;
    logic                   done;
    logic [ADDR_W-1:0]      mem_addr;
    logic [ADDR_W-1:0]      mem_wdata;
    logic                   mem_wren;
    logic [ADDR_W-1:0]      mem_rdata;

    modport master (
        input  start, init_en, secret_key, mem_rdata,
        output busy, done, mem_addr, mem_wdata, mem_wren
    );

    modport slave (
        output start, init_en, secret_key, mem_rdata,
        input  busy, done, mem_addr, mem_wdata, mem_wren
    );
endinterface

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: optional identity fill of S, then the KSA swap loop
// over a single-port S RAM with RD_LAT-cycle read latency.
module rc4_ksa_engine
    import rc4_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned KEY_BYTES = 3,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    rc4_ksa_engine_if.master bus
);
    localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam int unsigned WW = $clog2(RD_LAT + 1);
    localparam int unsigned SW = ADDR_W + 9;

    ksa_state_t             state_q, state_d;
    logic [ADDR_W-1:0]      i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [KW-1:0]          k_q, k_d;
    logic [WW-1:0]          wait_q, wait_d;
    logic [KEY_BYTES*8-1:0] key_q, key_d;
    logic [MaxKeyBytes*8-1:0] key_ext;
    logic [7:0]             kb;
    logic [SW-1:0]          j_sum;
    logic [ADDR_W-1:0]      j_next;
    logic                   wait_last;

    always_comb begin
        key_ext = '0;
        key_ext[KEY_BYTES*8-1:0] = key_q;
        kb     = key_byte(key_ext, KEY_BYTES, 32'(k_q));
        j_sum  = SW'(j_q) + SW'(si_q) + SW'(kb);
        j_next = j_sum[ADDR_W-1:0];
    end

    assign wait_last = (wait_q == WW'(RD_LAT - 1));

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            wait_q  <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            wait_q  <= wait_d;
            key_q   <= key_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        j_d           = j_q;
        k_d           = k_q;
        si_d          = si_q;
        sj_d          = sj_q;
        wait_d        = wait_q;
        key_d         = key_q;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wren  = 1'b0;
        bus.done      = 1'b0;
        bus.busy      = (state_q != StIdle) && (state_q != StDone);

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    key_d   = bus.secret_key;
                    state_d = bus.init_en ? StInit : StRdSi;
                end
            end
            StInit: begin
                bus.mem_addr  = i_q;
                bus.mem_wdata = i_q;
                bus.mem_wren  = 1'b1;
                if (i_q == '1) begin
                    i_d     = '0;
                    state_d = StRdSi;
                end else begin
                    i_d = i_q + ADDR_W'(1);
                end
            end
            StRdSi: begin
                bus.mem_addr = i_q;
                wait_d       = '0;
                state_d      = StWaitSi;
            end
            StWaitSi: begin
                bus.mem_addr = i_q;
                if (wait_last) begin
                    si_d    = bus.mem_rdata;
                    state_d = StCalcJ;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            // The new j is presented straight away, so this cycle also issues the sj read.
            StCalcJ: begin
                bus.mem_addr = j_next;
                j_d          = j_next;
                k_d          = (k_q == KW'(KEY_BYTES - 1)) ? '0 : k_q + KW'(1);
                wait_d       = '0;
                state_d      = StWaitSj;
            end
            StWaitSj: begin
                bus.mem_addr = j_q;
                if (wait_last) begin
                    sj_d    = bus.mem_rdata;
                    state_d = StWrSi;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            StWrSi: begin
                bus.mem_addr  = i_q;
                bus.mem_wdata = sj_q;
                bus.mem_wren  = 1'b1;
                state_d       = StWrSj;
            end
            StWrSj: begin
                bus.mem_addr  = j_q;
                bus.mem_wdata = si_q;
                bus.mem_wren  = 1'b1;
                if (i_q == '1) begin
                    i_d     = '0;
                    state_d = StDone;
                end else begin
                    i_d     = i_q + ADDR_W'(1);
                    state_d = StRdSi;
                end
            end
            StDone: begin
                bus.done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
